// File: rtl/fifo32k_rd_ctrl.sv
// Read-side controller for the 32k x 14b capture FIFO: drains one burst per start and
// streams MSB-justified 16-bit samples. Define FIFO32K_RD_TIMEOUT_EN for the FIFO-empty watchdog.
module fifo32k_rd_ctrl #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             rdclk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [1:0]       bw_bits,
  input  logic             fifo_empty,
  output logic             fifo_rden,
  input  logic [13:0]      fifo_dout,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining,
  output logic             timeout_err
);

`ifdef FIFO32K_RD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] justify(input logic [13:0] d, input logic [1:0] bw);
    logic [15:0] r;
    case (bw)
      2'b00:   r = {d[7:0], 8'b0};
      2'b01:   r = {d[9:0], 6'b0};
      2'b10:   r = {d[11:0], 4'b0};
      default: r = {d[13:0], 2'b0};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [1:0]       bw_q, bw_d;
  logic             inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             skid_v_q, skid_v_d;
  logic [15:0]      skid_q, skid_d;
  logic             done_q, done_d;
  logic             timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic             pop;
  logic             rden;
  logic             credit_ok;
  logic [1:0]       occ;
  logic [15:0]      push_word;

  // Read issue: out_data_q is the skid head, skid_q the second slot. A read is only
  // issued if the word it returns next cycle is guaranteed a slot.
  always_comb begin
    occ       = {1'b0, out_valid_q} + {1'b0, skid_v_q};
    pop       = out_valid_q && out_ready;
    credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    rden      = (state_q == S_READ) && (issued_q < len_q) && !fifo_empty && credit_ok;
    push_word = justify(fifo_dout, bw_q);
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    issued_d      = issued_q;
    remaining_d   = remaining_q;
    bw_d          = bw_q;
    inflight_d    = rden;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    skid_v_d      = skid_v_q;
    skid_d        = skid_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    to_cnt_d      = to_cnt_q;

    // Pop first, then land the returning word in the first free slot (FIFO order)
    if (pop) begin
      out_valid_d = skid_v_q;
      if (skid_v_q) out_data_d = skid_q;
      skid_v_d = 1'b0;
    end
    if (inflight_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_data_d  = push_word;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = push_word;
      end
    end

    if (rden) issued_d = issued_q + 1'b1;
    if (pop)  remaining_d = remaining_q - 1'b1;

    if (TO_EN && (state_q == S_READ)) begin
      if (rden)
        to_cnt_d = '0;
      else if ((issued_q < len_q) && fifo_empty)
        to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d         = burst_len;
          bw_d          = bw_bits;
          remaining_d   = burst_len;
          issued_d      = '0;
          to_cnt_d      = '0;
          timeout_err_d = 1'b0;
          state_d       = (burst_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else if (TO_EN && (to_cnt_d == TO_W'(TIMEOUT))) begin
          timeout_err_d = 1'b1;
          state_d       = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Nothing can be in flight here, so an empty skid after this edge means the burst is over
        if (!out_valid_d && !skid_v_d) state_d = S_DONE;
      end
      S_DONE: begin
        if (!done_q) done_d = 1'b1;
        else         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      issued_q      <= '0;
      remaining_q   <= '0;
      bw_q          <= '0;
      inflight_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      skid_v_q      <= 1'b0;
      skid_q        <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      remaining_q   <= remaining_d;
      bw_q          <= bw_d;
      inflight_q    <= inflight_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      skid_v_q      <= skid_v_d;
      skid_q        <= skid_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  // A returning word with both slots full and no pop would be lost
  a_no_skid_overflow: assert property (@(posedge rdclk) disable iff (rst)
    !(inflight_q && out_valid_q && skid_v_q && !pop));

  assign fifo_rden   = rden;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign remaining   = remaining_q;
  assign timeout_err = TO_EN && timeout_err_q;

endmodule

// File: doc/fifo32k_rd_ctrl.md
# fifo32k_rd_ctrl

Read-side controller for the 32k-sample, 14-bit capture FIFO. It runs in the rdclk domain and drains a host-requested number of samples from the FIFO. It issues one FIFO read enable per sample, absorbing the FIFO's 1-cycle read latency with a 2-entry skid buffer. Samples are delivered MSB-justified to 16 bits, according to the converter resolution latched at burst start, over a valid/ready stream to the host interface.

## Interface
Parameters:
- LEN_W, 16, width of burst length and remaining count; maximum burst is 32768.
- TIMEOUT, 1024, consecutive FIFO-empty cycles before abort; used only with the macro.

Ports:
- rdclk  in  1  read clock; all logic is posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle burst request; accepted only in IDLE.
- burst_len  in  LEN_W  number of samples to deliver; sampled with start.
- bw_bits  in  2  resolution: 00=8b, 01=10b, 10=12b, 11=14b; sampled with start.
- fifo_empty  in  1  FIFO empty flag, rdclk domain.
- fifo_rden  out  1  FIFO read enable; one sample per high cycle.
- fifo_dout  in  14  FIFO data; valid in the cycle after fifo_rden.
- out_data  out  16  justified sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts when out_valid && out_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at burst end.
- remaining  out  LEN_W  samples not yet accepted by the host.
- timeout_err  out  1  sticky abort flag; cleared by the next accepted start.

## Operation
- States:
  - IDLE: start, then READ. If burst_len==0, go to DONE instead.
  - READ: issue reads. Go to DRAIN when issued==len.
  - DRAIN: wait for in-flight and buffered words to be accepted. Go to DONE when remaining==0.
  - DONE: pulse done for 1 cycle, then go to IDLE.
- fifo_rden = READ && issued<len && !fifo_empty && (occ + inflight − pop) < 2.
  - occ is skid occupancy (0..2).
  - inflight is fifo_rden delayed by one cycle.
  - pop = out_valid && out_ready.
- Skid buffer is FIFO-ordered. When inflight is set, fifo_dout is written on that edge. Simultaneous push and pop is allowed. The skid never overflows; an overflow is a design error.
- Justification uses bw_bits as latched at start:
  - 00: {dout[7:0], 8'b0}
  - 01: {dout[9:0], 6'b0}
  - 10: {dout[11:0], 4'b0}
  - 11: {dout[13:0], 2'b0}
  - Unused upper bits are discarded.
- remaining loads burst_len at start and decrements on each pop.
- start while busy is ignored, as is any change to burst_len or bw_bits during a burst.
- The controller never reads more than burst_len words. Words left in the FIFO remain for the next burst.

## Timing
- Reset values:
  - State IDLE.
  - fifo_rden, out_valid, busy, done, timeout_err = 0.
  - out_data = 0, remaining = 0.
  - Skid buffer and all counters cleared.
- Reset is asynchronous and may occur mid-burst. fifo_rden drops immediately and any in-flight word is discarded.
- Latency, with fifo_empty low and out_ready high:
  - Edge E0 samples start.
  - fifo_rden is high after E0.
  - The word is captured at E2.
  - out_valid is high after E2.
- Throughput is 1 sample/cycle sustained while out_ready=1 and the FIFO is not empty.
- When out_ready drops, at most 2 words are held and fifo_rden deasserts the same cycle the credit runs out. The stream resumes without bubbles once out_ready returns.
- out_data and out_valid are registered and held stable while out_valid && !out_ready.
- done is high for exactly one cycle, one edge after the last pop. busy goes low on the following edge.
- Zero-length burst: done is asserted 1 cycle after start, with no fifo_rden.

## Configuration
- FIFO32K_RD_TIMEOUT_EN defined:
  - A counter counts consecutive READ cycles with issued<len and fifo_empty=1, and resets on any fifo_rden.
  - When the count reaches TIMEOUT, timeout_err is set, reads stop, the state goes to DRAIN, and done pulses after the buffered words are accepted.
  - remaining holds the undelivered count.
- Undefined: the controller waits indefinitely for data, and timeout_err is tied to 0.

## Test plan
- burst_len=4, bw_bits=11, FIFO holds 0x3FFF, 0x0001, 0x2AAA, 0x1555, out_ready=1 → out_data = 0xFFFC, 0x0004, 0xAAA8, 0x5554 on 4 consecutive cycles. done pulses once, with remaining=0.
- bw_bits=00, FIFO word 0x12A5 → out_data = 0xA500. With bw_bits=10, the same word gives out_data = 0x2A50.
- burst_len=8, out_ready toggled 1/0 every 2 cycles → all 8 words are delivered in order with none duplicated or lost, and at most 2 fifo_rden are outstanding while out_ready=0.
- burst_len=0 → done is asserted 1 cycle after start, fifo_rden is never high, and busy is high for 2 cycles.
- rst asserted mid-burst after 3 of 10 words → all outputs return to their reset values asynchronously. A new start with burst_len=2 then delivers the next 2 FIFO words.
- With FIFO32K_RD_TIMEOUT_EN and TIMEOUT=16: burst_len=5, FIFO holds 2 words → 2 words are delivered, timeout_err=1, done pulses, and remaining=3.
